// File: rtl/lifo_stack_ctrl.sv
// LIFO stack controller and storage; the stack pointer lives in an external
// counter_5bit driven through cntU/cntD/rst5 and read back on count/down_done.
module lifo_stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid_out,
  output logic              ready,
  output logic              full,
  output logic              empty,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              cntU,
  output logic              cntD,
  output logic              rst5,
  input  logic [4:0]        count,
  input  logic              down_done
);

  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DATA,
    CLR
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wreg;

  logic push_ok, push_rej, pop_ok, pop_rej;

  assign full  = (count == DEPTH_CNT);
  assign empty = down_done;
  assign ready = (state == IDLE);

  // clear outranks push, push outranks pop; a pop alongside a push is dropped silently
  assign push_ok  = ready && !clear && push && !full;
  assign push_rej = ready && !clear && push && full;
  assign pop_ok   = ready && !clear && !push && pop && !empty;
  assign pop_rej  = ready && !clear && !push && pop && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cntU      = 1'b0;
    cntD      = 1'b0;
    rst5      = 1'b0;
    case (state)
      IDLE: begin
        if (ready && clear) state_nxt = CLR;
        else if (push_ok)   state_nxt = WRITE;
        else if (pop_ok)    state_nxt = READ;
      end
      WRITE: begin
        cntU      = 1'b1;
        state_nxt = IDLE;
      end
      READ: begin
        cntD      = 1'b1;
        state_nxt = DATA;
      end
      DATA:    state_nxt = IDLE;
      CLR: begin
        rst5      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wreg          <= '0;
      dout          <= '0;
      valid_out     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_ok) wreg <= din;
      // count has already been decremented by the time DATA is reached
      if (state == DATA) dout <= mem[count];
      valid_out     <= (state == DATA);
      overflow_err  <= push_rej;
      underflow_err <= pop_rej;
    end
  end

  // Storage is not reset; a write coinciding with reset assertion is dropped.
  always_ff @(posedge clk) begin
    if (state == WRITE && !rst) mem[count] <= wreg;
  end

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Directed bench for lifo_stack_ctrl with a behavioural stand-in for counter_5bit.
module tb_lifo_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0, pop = 1'b0, clear = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       valid_out, ready, full, empty, overflow_err, underflow_err;
  logic       cntU, cntD, rst5;
  logic [4:0] count;
  logic       down_done;

  int errors = 0;
  int checks = 0;
  int bad_dec = 0;
  int bad_moore = 0;
  int valid_seen = 0;

  always #5 clk = ~clk;

  lifo_stack_ctrl #(.DATA_W(8), .DEPTH(31)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear), .din(din),
    .dout(dout), .valid_out(valid_out), .ready(ready), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .cntU(cntU), .cntD(cntD), .rst5(rst5), .count(count), .down_done(down_done)
  );

  // counter_5bit stand-in
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (rst5) count <= '0;
    else if (cntU) count <= count + 5'd1;
    else if (cntD) count <= count - 5'd1;
  end
  assign down_done = (count == 5'd0);

  always @(negedge clk) begin
    if (cntD && count == 5'd0) bad_dec++;
    if ((32'(cntU) + 32'(cntD) + 32'(rst5)) > 1) bad_moore++;
    if (valid_out) valid_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] d);
    push = 1'b1; din = d;
    tick();
    push = 1'b0;
    tick();
  endtask

  task automatic do_pop(output logic cntd_rd, output logic early_v,
                        output logic v, output logic [7:0] d);
    pop = 1'b1;
    tick();
    cntd_rd = cntD;
    early_v = valid_out;
    pop = 1'b0;
    tick();
    early_v = early_v | valid_out;
    tick();
    v = valid_out;
    d = dout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({empty, full, ready} !== 3'b101) begin
      errors++; $display("FAIL reset_flags got=%b exp=101", {empty, full, ready});
    end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++;
    if ({cntU, cntD, rst5, valid_out} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {cntU, cntD, rst5, valid_out});
    end
  endtask

  task automatic test_push_pop();
    logic c, e, v;
    logic [7:0] d;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hC3; exp_d[1] = 8'hB2; exp_d[2] = 8'hA1;
    push = 1'b1; din = 8'hA1;
    tick();
    push = 1'b0;
    checks++;
    if ({ready, cntU} !== 2'b01) begin
      errors++; $display("FAIL write_phase ready_cntU got=%b exp=01", {ready, cntU});
    end
    tick();
    do_push(8'hB2);
    do_push(8'hC3);
    checks++;
    if (count !== 5'd3) begin errors++; $display("FAIL push3_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      do_pop(c, e, v, d);
      checks++;
      if ({c, e, v} !== 3'b101) begin
        errors++; $display("FAIL pop%0d_timing cntD_early_valid got=%b exp=101", i, {c, e, v});
      end
      checks++;
      if (d !== exp_d[i]) begin errors++; $display("FAIL pop%0d_data got=%h exp=%h", i, d, exp_d[i]); end
    end
    tick();
    checks++;
    if ({count, empty, valid_out} !== {5'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL popped_out count=%0d empty=%b valid=%b exp 0 1 0", count, empty, valid_out);
    end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if ({underflow_err, cntD, ready} !== 3'b101) begin
      errors++; $display("FAIL underflow_pulse got=%b exp=101", {underflow_err, cntD, ready});
    end
    tick();
    checks++;
    if ({underflow_err, count} !== {1'b0, 5'd0}) begin
      errors++; $display("FAIL underflow_after err=%b count=%0d exp 0 0", underflow_err, count);
    end
  endtask

  task automatic test_overflow();
    logic c, e, v;
    logic [7:0] d;
    for (int i = 0; i < 31; i++) do_push(8'h40 + 8'(i));
    checks++;
    if ({full, count} !== {1'b1, 5'd31}) begin
      errors++; $display("FAIL fill_31 full=%b count=%0d exp 1 31", full, count);
    end
    push = 1'b1; din = 8'hEE;
    tick();
    push = 1'b0;
    checks++;
    if ({overflow_err, cntU, ready} !== 3'b101) begin
      errors++; $display("FAIL overflow_pulse got=%b exp=101", {overflow_err, cntU, ready});
    end
    tick();
    checks++;
    if ({overflow_err, count} !== {1'b0, 5'd31}) begin
      errors++; $display("FAIL overflow_after err=%b count=%0d exp 0 31", overflow_err, count);
    end
    do_pop(c, e, v, d);
    checks++;
    if ({v, d} !== {1'b1, 8'h5E}) begin
      errors++; $display("FAIL pop_top_of_full valid=%b dout=%h exp 1 5e", v, d);
    end
  endtask

  task automatic test_back_to_back();
    logic c, e, v;
    logic [7:0] d;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) do_push(8'h10 + 8'(i));
    checks++;
    if (count !== 5'd5) begin errors++; $display("FAIL refill5 got=%0d exp=5", count); end
    push = 1'b1; pop = 1'b1; din = 8'h77;
    tick();
    push = 1'b0;
    checks++;
    if ({cntU, cntD, underflow_err} !== 3'b100) begin
      errors++; $display("FAIL push_pop_same got=%b exp=100", {cntU, cntD, underflow_err});
    end
    // pop still high during WRITE must be ignored, not queued
    tick();
    pop = 1'b0;
    tick();
    checks++;
    if ({count, ready} !== {5'd6, 1'b1}) begin
      errors++; $display("FAIL push_pop_count count=%0d ready=%b exp 6 1", count, ready);
    end
    do_pop(c, e, v, d);
    checks++;
    if ({v, d, count} !== {1'b1, 8'h77, 5'd5}) begin
      errors++; $display("FAIL pop_after_pair valid=%b dout=%h count=%0d exp 1 77 5", v, d, count);
    end
    do_push(8'h88);
  endtask

  task automatic test_clear();
    clear = 1'b1; push = 1'b1;
    tick();
    clear = 1'b0; push = 1'b0;
    checks++;
    if ({rst5, cntU, ready} !== 3'b100) begin
      errors++; $display("FAIL clear_pulse got=%b exp=100", {rst5, cntU, ready});
    end
    tick();
    checks++;
    if ({count, empty, rst5, dout} !== {5'd0, 1'b1, 1'b0, 8'h77}) begin
      errors++; $display("FAIL clear_after count=%0d empty=%b rst5=%b dout=%h exp 0 1 0 77",
                         count, empty, rst5, dout);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    for (int i = 0; i < 4; i++) do_push(8'h20 + 8'(i));
    v0 = valid_seen;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if ({cntD, count} !== {1'b1, 5'd4}) begin
      errors++; $display("FAIL read_entry cntD=%b count=%0d exp 1 4", cntD, count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count, ready, cntD} !== {5'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_reset count=%0d ready=%b cntD=%b exp 0 1 0", count, ready, cntD);
    end
    tick();
    #2 rst = 1'b0;
    repeat (4) tick();
    checks++;
    if ({valid_seen == v0, ready, count} !== {1'b1, 1'b1, 5'd0}) begin
      errors++; $display("FAIL after_mid_reset valid_pulses=%0d ready=%b count=%0d exp 0 1 0",
                         valid_seen - v0, ready, count);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (bad_dec !== 0) begin errors++; $display("FAIL decrement_at_zero got=%0d exp=0", bad_dec); end
    checks++;
    if (bad_moore !== 0) begin errors++; $display("FAIL one_hot_ctrl got=%0d exp=0", bad_moore); end
  endtask

  initial begin
    #1;
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end

endmodule
